instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue_pkg.sv | 18 +
 rtl/instr_prefetch_queue_if.sv | 30 +++
 rtl/instr_prefetch_queue_sync_fifo.sv | 61 ++++++
 rtl/instr_prefetch_queue.sv | 125 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// rtl/instr_prefetch_queue_pkg.sv - shared constants and types for the instruction prefetch queue
// Contents: default reset PC, NOP encoding, RUN/DRAIN state type, word alignment helper.
package instr_prefetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // RUN: every response is live. DRAIN: responses issued before a redirect are still returning.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pf_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - instruction memory request/response bus
// Signals: mem_req_valid/mem_req_addr/mem_req_ready (request handshake),
//          mem_rsp_valid/mem_rsp_data (in-order read data, no backpressure).
// Modports: master = prefetcher side, slave = memory side.
interface instr_prefetch_queue_if;
  import instr_prefetch_queue_pkg::*;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// rtl/instr_prefetch_queue_sync_fifo.sv - register-array FIFO with push/pop/flush
// Ports: clk, rst (async active-low), push/push_data, pop, flush,
//        head (entry at read pointer), full, empty, count (0..DEPTH).
// Push is accepted while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import instr_prefetch_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      // Collapse onto the read pointer so head keeps showing the last value.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - credit-based instruction prefetcher with redirect and stale-response drain
// Ports: clk, rst (async active-low); PCSrcE/PCTargetE redirect from execute;
//        imem (master side of the memory bus); InstrValidF/InstrF/PCF/PCPlus4F head of
//        the instruction queue; InstrTakeF decode accepts head.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PCSrcE,
  input  logic [31:0]                   PCTargetE,
  instr_prefetch_queue_if.master        imem,
  output logic                          InstrValidF,
  output logic [31:0]                   InstrF,
  output logic [31:0]                   PCF,
  output logic [31:0]                   PCPlus4F,
  input  logic                          InstrTakeF
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e    state;
  logic [31:0]  fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] stale_left;

  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic [63:0]   q_head;

  logic [31:0]   pc_head;
  logic [CW-1:0] pcq_count;
  logic          pcq_full;
  logic          pcq_empty;

  logic [CW:0]   inflight_total;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          take;
  logic          unused_status;

  // Queue slots already filled plus slots promised to in-flight reads must fit the queue,
  // which is what keeps the instruction queue from ever overflowing.
  assign inflight_total = {1'b0, q_count} + {1'b0, outstanding};
  assign credit_ok      = inflight_total < (CW+1)'(DEPTH);

  // rst gates the request combinationally so it is low for the whole reset window.
  assign imem.mem_req_valid = rst && !PCSrcE && credit_ok;
  assign imem.mem_req_addr  = fetch_pc;

  assign req_fire = imem.mem_req_valid && imem.mem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp_ok   = imem.mem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && !PCSrcE && (state == RUN);
  assign take     = InstrValidF && InstrTakeF && !PCSrcE;

  // Reads still owed by memory once this cycle's response (if any) is counted.
  assign stale_left = outstanding - CW'(rsp_ok);

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_ok),
    .flush     (1'b0),
    .head      (pc_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({pc_head, imem.mem_rsp_data}),
    .pop       (take),
    .flush     (PCSrcE),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign unused_status = ^{pcq_full, pcq_empty, pcq_count, q_full};

  assign InstrValidF = !q_empty;
  assign PCF         = q_head[63:32];
  assign InstrF      = q_head[31:0];
  assign PCPlus4F    = PCF + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (PCSrcE) begin
        // Every read still owed belongs to the old path; reload even when already draining.
        fetch_pc <= word_align(PCTargetE);
        discard  <= stale_left;
        state    <= (stale_left != '0) ? DRAIN : RUN;
      end else if ((state == DRAIN) && rsp_ok) begin
        discard <= discard - 1'b1;
        if (discard == CW'(1)) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
  import instr_prefetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        InstrTakeF = 1'b0;
  logic        InstrValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem        (bus),
    .InstrValidF (InstrValidF),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .InstrTakeF  (InstrTakeF)
  );

  always #5 clk = ~clk;

  // Memory model: accepted addresses tagged with the redirect epoch they were issued in.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  req_t        mem_q[$];
  int          epoch = 0;
  int          occ = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_fetch = '0;

  logic        s_reqv, s_acc, s_valid, s_pop, s_rsp;
  logic [31:0] s_addr, s_pcf, s_instr, s_p4;
  int          s_occ, s_out;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0013;
  endfunction

  // One clock cycle; entered just after a falling edge, leaves just after the next one.
  task automatic tick(input bit take, input bit redir, input logic [31:0] tgt,
                      input bit ready, input bit rsp_en);
    req_t r;
    InstrTakeF = take;
    PCSrcE = redir;
    PCTargetE = tgt;
    bus.mem_req_ready = ready;
    if (rsp_en && mem_q.size() > 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = $urandom;
    end
    #1;
    s_reqv  = bus.mem_req_valid;
    s_addr  = bus.mem_req_addr;
    s_acc   = bus.mem_req_valid && ready;
    s_valid = InstrValidF;
    s_pop   = InstrValidF && take && !redir;
    s_pcf   = PCF;
    s_instr = InstrF;
    s_p4    = PCPlus4F;
    s_rsp   = bus.mem_rsp_valid;
    s_occ   = occ;
    s_out   = mem_q.size();
    @(posedge clk);
    if (s_rsp) begin
      r = mem_q.pop_front();
      if (!redir && r.epoch == epoch) occ++;
    end
    if (s_pop) occ--;
    if (redir) begin
      occ = 0;
      epoch++;
    end
    if (s_acc) mem_q.push_back('{s_addr, epoch});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    InstrTakeF = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    mem_q.delete();
    occ = 0;
    epoch++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC;
    exp_fetch = RESET_PC;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== RESET_PC || InstrValidF !== 1'b0 ||
        InstrF !== 32'h0 || PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_outputs: req_valid=%b addr=%h valid=%b instr=%h pcf=%h p4=%h required 0 %h 0 0 0 4",
               bus.mem_req_valid, bus.mem_req_addr, InstrValidF, InstrF, PCF, PCPlus4F, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL first_request: req_valid=%b addr=%h required 1 %h", bus.mem_req_valid, bus.mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int pops = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL stream_pop: pcf=%h instr=%h p4=%h required pcf=%h instr=%h", s_pcf, s_instr, s_p4, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    vectors++;
    if (pops != 18) begin
      miscompares++;
      $display("FAIL stream_count: pops=%0d required 18", pops);
    end
  endtask

  task automatic test_stall();
    int accepted = 0;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (s_acc) accepted++;
    end
    vectors++;
    if (accepted != DEPTH || s_reqv !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_credit: accepted=%0d last_req_valid=%b required %0d 0", accepted, s_reqv, DEPTH);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL stall_release_pop: pcf=%h instr=%h p4=%h required pcf=%h", s_pcf, s_instr, s_p4, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    vectors++;
    if (pops < 8) begin
      miscompares++;
      $display("FAIL stall_release_count: pops=%0d required >=8", pops);
    end
  endtask

  task automatic test_redirect();
    int pops = 0;
    do_reset();
    repeat (3) tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (mem_q.size() != 3) begin
      miscompares++;
      $display("FAIL redirect_outstanding: outstanding=%0d required 3", mem_q.size());
    end
    tick(1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
    vectors++;
    if (s_reqv !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_no_req: req_valid=%b required 0", s_reqv);
    end
    exp_pc = 32'h0000_0100;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
      if (i == 0) begin
        vectors++;
        if (s_reqv !== 1'b1 || s_addr !== 32'h0000_0100) begin
          miscompares++;
          $display("FAIL redirect_addr: req_valid=%b addr=%h required 1 00000100", s_reqv, s_addr);
        end
      end
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL redirect_pop: pcf=%h instr=%h required pcf=%h instr=%h", s_pcf, s_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    vectors++;
    if (pops == 0) begin
      miscompares++;
      $display("FAIL redirect_progress: pops=0 required >0");
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] t1, t2;
    int pops = 0;
    do_reset();
    repeat (3) tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
    t1 = $urandom;
    t2 = $urandom;
    tick(1'b1, 1'b1, t1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (s_valid !== 1'b0 || s_reqv !== 1'b1 || s_addr !== word_align(t1)) begin
      miscompares++;
      $display("FAIL drain_first: valid=%b req_valid=%b addr=%h required 0 1 %h", s_valid, s_reqv, s_addr, word_align(t1));
    end
    tick(1'b1, 1'b1, t2, 1'b1, 1'b1);
    exp_pc = word_align(t2);
    for (int i = 0; i < 40; i++) begin
      tick(($urandom % 4) != 0, 1'b0, '0, ($urandom % 4) != 0, ($urandom % 3) != 0);
      vectors++;
      if (s_valid !== (s_occ > 0)) begin
        miscompares++;
        $display("FAIL drain_valid: valid=%b required %b", s_valid, s_occ > 0);
      end
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc)) begin
          miscompares++;
          $display("FAIL drain_pop: pcf=%h instr=%h required pcf=%h instr=%h", s_pcf, s_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    vectors++;
    if (pops == 0) begin
      miscompares++;
      $display("FAIL drain_progress: pops=0 required >0");
    end
  endtask

  task automatic test_random();
    bit          take, redir, ready, rsp_en;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      take   = ($urandom % 4) != 0;
      ready  = ($urandom % 4) != 0;
      rsp_en = ($urandom % 3) != 0;
      redir  = ($urandom % 30) == 0;
      tgt    = $urandom;
      if ($urandom % 2) tgt = 32'hFFFF_FFE0 | ($urandom % 32);
      tick(take, redir, tgt, ready, rsp_en);
      vectors++;
      if (s_reqv !== (!redir && (s_occ + s_out) < DEPTH)) begin
        miscompares++;
        $display("FAIL random_req_valid: req_valid=%b occ=%0d outstanding=%0d redirect=%b", s_reqv, s_occ, s_out, redir);
      end
      if (s_reqv) begin
        vectors++;
        if (s_addr !== exp_fetch) begin
          miscompares++;
          $display("FAIL random_req_addr: addr=%h required %h", s_addr, exp_fetch);
        end
      end
      if (s_acc) exp_fetch = exp_fetch + 32'd4;
      vectors++;
      if (s_valid !== (s_occ > 0) || s_occ > DEPTH || s_out > DEPTH) begin
        miscompares++;
        $display("FAIL random_occupancy: valid=%b occ=%0d outstanding=%0d limit %0d", s_valid, s_occ, s_out, DEPTH);
      end
      if (s_pop) begin
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL random_pop: pcf=%h instr=%h p4=%h required pcf=%h instr=%h", s_pcf, s_instr, s_p4, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        exp_pc    = word_align(tgt);
        exp_fetch = word_align(tgt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== RESET_PC || InstrValidF !== 1'b0 ||
        InstrF !== 32'h0 || PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_async: req_valid=%b addr=%h valid=%b instr=%h pcf=%h p4=%h required 0 %h 0 0 0 4",
               bus.mem_req_valid, bus.mem_req_addr, InstrValidF, InstrF, PCF, PCPlus4F, RESET_PC);
    end
    mem_q.delete();
    occ = 0;
    epoch++;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b1);
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_pcf !== exp_pc || s_instr !== instr_of(exp_pc)) begin
          miscompares++;
          $display("FAIL reset_refetch: pcf=%h instr=%h required pcf=%h", s_pcf, s_instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    vectors++;
    if (pops != 8) begin
      miscompares++;
      $display("FAIL reset_refetch_count: pops=%0d required 8", pops);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_drain();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
